// File: rtl/dht11_poll_ctrl.sv
// DHT11 measurement scheduler: manual/periodic requests, guard spacing, timeout and retry.
// Optional `DHT11_RANGE_CHK_EN` rejects out-of-range humidity/temperature readings as errors.
module dht11_poll_ctrl #(
  parameter int VALUE_SZ    = 16,
  parameter int PERIOD_CYC  = 100_000_000,
  parameter int GUARD_CYC   = 50_000_000,
  parameter int TIMEOUT_CYC = 2_500_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic                CLK,
  input  logic                RST_n,
  input  logic                I_START,
  input  logic                I_AUTO,
  output logic                O_DRV_EN,
  input  logic                I_DRV_BUSY,
  input  logic                I_DRV_ERR,
  input  logic [VALUE_SZ-1:0] I_DRV_VALUE,
  output logic [VALUE_SZ-1:0] O_VALUE,
  output logic                O_VALID,
  output logic                O_UPDATE,
  output logic                O_FAIL,
  output logic [7:0]          O_ERR_CNT,
  output logic                O_BUSY
);

  localparam int PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int GW = $clog2(GUARD_CYC + 1);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYC - 1);
  localparam logic [PW-1:0] P_ONE    = PW'(1);
  localparam logic [GW-1:0] GUARD_LD = GW'(GUARD_CYC);
  localparam logic [GW-1:0] G_ONE    = GW'(1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [RW-1:0] R_ONE    = RW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    EVAL      = 3'd4,
    RETRY     = 3'd5
  } state_t;

  state_t                state_r;
  logic                  start_d_r;
  logic                  busy_d_r;
  logic [PW-1:0]         per_r;
  logic [GW-1:0]         guard_r;
  logic [TW-1:0]         to_r;
  logic [RW-1:0]         retry_r;
  logic                  pending_r;
  logic                  cap_err_r;
  logic [VALUE_SZ-1:0]   cap_val_r;
  logic                  req_s;
  logic                  eval_err_s;

`ifdef DHT11_RANGE_CHK_EN
  function automatic logic range_bad(input logic [VALUE_SZ-1:0] v);
    return (v[15:8] > 8'd100) || (v[7:0] > 8'd60);
  endfunction
`endif

  // Request sources: I_START rising edge or an auto-mode period tick.
  always_comb begin
    req_s = (I_START && !start_d_r) || (I_AUTO && (per_r == PER_LAST));
  end

  // Verdict for EVAL; a timeout is folded into cap_err_r.
  always_comb begin
`ifdef DHT11_RANGE_CHK_EN
    eval_err_s = cap_err_r || range_bad(cap_val_r);
`else
    eval_err_s = cap_err_r;
`endif
  end

  // Input edge history and the auto-mode period counter.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      start_d_r <= 1'b0;
      busy_d_r  <= 1'b0;
      per_r     <= '0;
    end else begin
      start_d_r <= I_START;
      busy_d_r  <= I_DRV_BUSY;
      if (!I_AUTO || (per_r == PER_LAST)) begin
        per_r <= '0;
      end else begin
        per_r <= per_r + P_ONE;
      end
    end
  end

  // Transaction FSM with pending flag, guard/timeout counters and registered outputs.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_r   <= IDLE;
      guard_r   <= '0;
      to_r      <= '0;
      retry_r   <= '0;
      pending_r <= 1'b0;
      cap_err_r <= 1'b0;
      cap_val_r <= '0;
      O_DRV_EN  <= 1'b0;
      O_VALUE   <= '0;
      O_VALID   <= 1'b0;
      O_UPDATE  <= 1'b0;
      O_FAIL    <= 1'b0;
      O_ERR_CNT <= 8'd0;
      O_BUSY    <= 1'b0;
    end else begin
      O_DRV_EN <= 1'b0;
      O_UPDATE <= 1'b0;
      if (guard_r != '0) guard_r <= guard_r - G_ONE;
      case (state_r)
        IDLE: begin
          if (pending_r && (guard_r == '0)) begin
            state_r   <= START;
            O_DRV_EN  <= 1'b1;
            O_BUSY    <= 1'b1;
            pending_r <= 1'b0;
          end
        end
        START: begin
          to_r    <= '0;
          state_r <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (I_DRV_BUSY) begin
            to_r    <= '0;
            state_r <= WAIT_DONE;
          end else if (to_r == TO_LAST) begin
            cap_err_r <= 1'b1;
            state_r   <= EVAL;
          end else begin
            to_r <= to_r + T_ONE;
          end
        end
        WAIT_DONE: begin
          if (busy_d_r && !I_DRV_BUSY) begin
            cap_err_r <= I_DRV_ERR;
            cap_val_r <= I_DRV_VALUE;
            state_r   <= EVAL;
          end else if (to_r == TO_LAST) begin
            cap_err_r <= 1'b1;
            state_r   <= EVAL;
          end else begin
            to_r <= to_r + T_ONE;
          end
        end
        EVAL: begin
          guard_r <= GUARD_LD;
          if (!eval_err_s) begin
            O_VALUE  <= cap_val_r;
            O_UPDATE <= 1'b1;
            O_VALID  <= 1'b1;
            O_FAIL   <= 1'b0;
            retry_r  <= '0;
            O_BUSY   <= 1'b0;
            state_r  <= IDLE;
          end else begin
            if (O_ERR_CNT != 8'hFF) O_ERR_CNT <= O_ERR_CNT + 8'd1;
            if ((int'(retry_r) + 1) < MAX_RETRY) begin
              retry_r <= retry_r + R_ONE;
              state_r <= RETRY;
            end else begin
              O_FAIL  <= 1'b1;
              retry_r <= '0;
              O_BUSY  <= 1'b0;
              state_r <= IDLE;
            end
          end
        end
        RETRY: begin
          if (guard_r == '0) begin
            state_r  <= START;
            O_DRV_EN <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          O_BUSY  <= 1'b0;
        end
      endcase
      // A new request in the START-entry cycle is a distinct request and survives the clear.
      if (req_s) pending_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dht11_poll_ctrl.sv
// Directed bench for dht11_poll_ctrl with a simple behavioural DHT11 reader model.
module tb_dht11_poll_ctrl;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b1;
  logic        I_START = 1'b0;
  logic        I_AUTO = 1'b0;
  logic        I_DRV_BUSY = 1'b0;
  logic        I_DRV_ERR = 1'b0;
  logic [15:0] I_DRV_VALUE = 16'h0000;
  logic        O_DRV_EN;
  logic [15:0] O_VALUE;
  logic        O_VALID;
  logic        O_UPDATE;
  logic        O_FAIL;
  logic [7:0]  O_ERR_CNT;
  logic        O_BUSY;

  dht11_poll_ctrl #(
    .VALUE_SZ(16), .PERIOD_CYC(200), .GUARD_CYC(20), .TIMEOUT_CYC(30), .MAX_RETRY(2)
  ) u_dut (
    .CLK(CLK), .RST_n(RST_n), .I_START(I_START), .I_AUTO(I_AUTO),
    .O_DRV_EN(O_DRV_EN), .I_DRV_BUSY(I_DRV_BUSY), .I_DRV_ERR(I_DRV_ERR),
    .I_DRV_VALUE(I_DRV_VALUE), .O_VALUE(O_VALUE), .O_VALID(O_VALID),
    .O_UPDATE(O_UPDATE), .O_FAIL(O_FAIL), .O_ERR_CNT(O_ERR_CNT), .O_BUSY(O_BUSY)
  );

  always #5 CLK = ~CLK;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          starts_q[$];
  int          upd_q[$];
  bit          rd_resp = 1'b1;
  int          rd_err_left = 0;
  logic [15:0] rd_val = 16'h0000;
  int          s0, u0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start;
    @(negedge CLK);
    I_START = 1'b1;
    @(negedge CLK);
    I_START = 1'b0;
  endtask

  // Cycle-stamped log of start pulses and update pulses.
  always @(negedge CLK) begin
    cyc++;
    if (O_DRV_EN === 1'b1) starts_q.push_back(cyc);
    if (O_UPDATE === 1'b1) upd_q.push_back(cyc);
  end

  // Reader model: busy 3 cycles after start, low again 10 cycles later.
  initial begin
    forever begin
      @(negedge CLK);
      if (O_DRV_EN === 1'b1 && rd_resp) begin
        repeat (3) @(negedge CLK);
        I_DRV_BUSY = 1'b1;
        repeat (10) @(negedge CLK);
        if (rd_err_left > 0) begin
          I_DRV_ERR   = 1'b1;
          I_DRV_VALUE = 16'hFFFF;
          rd_err_left--;
        end else begin
          I_DRV_ERR   = 1'b0;
          I_DRV_VALUE = rd_val;
        end
        I_DRV_BUSY = 1'b0;
      end
    end
  end

  initial begin
    #2 RST_n = 1'b0;
    #1;
    chk("rst_drv_en", O_DRV_EN, 0);
    chk("rst_value", O_VALUE, 0);
    chk("rst_valid", O_VALID, 0);
    chk("rst_fail", O_FAIL, 0);
    chk("rst_err_cnt", O_ERR_CNT, 0);
    chk("rst_busy", O_BUSY, 0);
    repeat (3) @(negedge CLK);
    RST_n = 1'b1;
    repeat (3) @(negedge CLK);

    // 1: single good read
    rd_resp = 1'b1; rd_err_left = 0; rd_val = 16'h2D17;
    s0 = starts_q.size(); u0 = upd_q.size();
    pulse_start();
    chk("t1_drv_en_early", O_DRV_EN, 0);
    @(negedge CLK);
    chk("t1_drv_en_lat", O_DRV_EN, 1);
    chk("t1_busy", O_BUSY, 1);
    repeat (40) @(negedge CLK);
    chk("t1_starts", starts_q.size() - s0, 1);
    chk("t1_updates", upd_q.size() - u0, 1);
    if (upd_q.size() > u0 && starts_q.size() > s0)
      chk("t1_upd_latency", upd_q[u0] - starts_q[s0], 15);
    chk("t1_value", O_VALUE, 16'h2D17);
    chk("t1_valid", O_VALID, 1);
    chk("t1_err_cnt", O_ERR_CNT, 0);
    chk("t1_fail", O_FAIL, 0);
    chk("t1_busy_end", O_BUSY, 0);

    // 2: requests during a transaction merge and wait out the guard
    rd_val = 16'h2E18;
    s0 = starts_q.size(); u0 = upd_q.size();
    pulse_start();
    repeat (5) @(negedge CLK);
    pulse_start();
    repeat (2) @(negedge CLK);
    pulse_start();
    repeat (100) @(negedge CLK);
    chk("t2_starts", starts_q.size() - s0, 2);
    chk("t2_updates", upd_q.size() - u0, 2);
    if (starts_q.size() > s0 + 1 && upd_q.size() > u0)
      chk("t2_guard_gap", starts_q[s0+1] - upd_q[u0], 21);
    chk("t2_value", O_VALUE, 16'h2E18);

    // 3: reader never answers, both attempts time out
    rd_resp = 1'b0;
    s0 = starts_q.size(); u0 = upd_q.size();
    pulse_start();
    repeat (150) @(negedge CLK);
    chk("t3_starts", starts_q.size() - s0, 2);
    if (starts_q.size() > s0 + 1)
      chk("t3_retry_gap", starts_q[s0+1] - starts_q[s0], 53);
    chk("t3_updates", upd_q.size() - u0, 0);
    chk("t3_fail", O_FAIL, 1);
    chk("t3_err_cnt", O_ERR_CNT, 2);
    chk("t3_value", O_VALUE, 16'h2E18);
    chk("t3_valid", O_VALID, 1);
    chk("t3_busy", O_BUSY, 0);

    // 4: first attempt errors, retry succeeds and clears O_FAIL
    rd_resp = 1'b1; rd_err_left = 1; rd_val = 16'h3A19;
    s0 = starts_q.size(); u0 = upd_q.size();
    pulse_start();
    repeat (150) @(negedge CLK);
    chk("t4_starts", starts_q.size() - s0, 2);
    if (starts_q.size() > s0 + 1)
      chk("t4_retry_gap", starts_q[s0+1] - starts_q[s0], 36);
    chk("t4_updates", upd_q.size() - u0, 1);
    chk("t4_err_cnt", O_ERR_CNT, 3);
    chk("t4_fail", O_FAIL, 0);
    chk("t4_value", O_VALUE, 16'h3A19);

    // 5: auto mode, one read per 200-cycle period
    rd_val = 16'h2D17;
    s0 = starts_q.size();
    @(negedge CLK);
    I_AUTO = 1'b1;
    repeat (1050) @(negedge CLK);
    I_AUTO = 1'b0;
    repeat (300) @(negedge CLK);
    chk("t5_starts", starts_q.size() - s0, 5);
    for (int i = 1; i < 5; i++) begin
      if (starts_q.size() > s0 + i)
        chk($sformatf("t5_spacing%0d", i), starts_q[s0+i] - starts_q[s0+i-1], 200);
    end
    chk("t5_value", O_VALUE, 16'h2D17);

    // 6: reset in WAIT_DONE, then optional range check
    rd_val = 16'h6510;
    pulse_start();
    repeat (6) @(negedge CLK);
    #2;
    chk("t6_busy_pre", O_BUSY, 1);
    RST_n = 1'b0;
    #1;
    chk("t6_rst_busy", O_BUSY, 0);
    chk("t6_rst_value", O_VALUE, 0);
    chk("t6_rst_valid", O_VALID, 0);
    chk("t6_rst_err_cnt", O_ERR_CNT, 0);
    chk("t6_rst_fail", O_FAIL, 0);
    chk("t6_rst_drv_en", O_DRV_EN, 0);
    @(negedge CLK);
    RST_n = 1'b1;
    s0 = starts_q.size();
    repeat (100) @(negedge CLK);
    chk("t6_no_start", starts_q.size() - s0, 0);
    pulse_start();
    repeat (150) @(negedge CLK);
`ifdef DHT11_RANGE_CHK_EN
    chk("t6_rng_starts", starts_q.size() - s0, 2);
    chk("t6_rng_value", O_VALUE, 0);
    chk("t6_rng_valid", O_VALID, 0);
    chk("t6_rng_err_cnt", O_ERR_CNT, 2);
    chk("t6_rng_fail", O_FAIL, 1);
`else
    chk("t6_rng_starts", starts_q.size() - s0, 1);
    chk("t6_rng_value", O_VALUE, 16'h6510);
    chk("t6_rng_valid", O_VALID, 1);
    chk("t6_rng_err_cnt", O_ERR_CNT, 0);
    chk("t6_rng_fail", O_FAIL, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
